video_object_tracker: RTL
=========================

# video_object_tracker

Passive consumer of the SDL-style pixel stream (hpos, vpos, visible, rgb) that the simulation top-levels drive out. Each frame it finds every visible pixel whose colour matches a target mask. At the end of the frame it reports the bounding box and pixel count of the matching pixels. It sits beside the SDL outputs, in simulation benches or on hardware, to check object position (for example, ball motion) without a frame grabber.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `V_ACTIVE`, default 480: visible lines per frame.
- `TARGET_RGB`, default 3'b111: colour to match, with bit0 = R, bit1 = G, bit2 = B.
- `RGB_MASK`, default 3'b111: selects which rgb bits take part in the comparison.
- `i_clk` in 1: pixel clock.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_hpos` in 10: horizontal position of the current pixel.
- `i_vpos` in 10: vertical position of the current pixel.
- `i_visible` in 1: the current pixel is in the active area.
- `i_rgb` in 3: pixel colour.
- `o_valid` out 1: one-cycle pulse when a frame result is published.
- `o_found` out 1: the last published frame contained at least one match.
- `o_x_min`, `o_x_max` out 10 each: horizontal bounding box of matches.
- `o_y_min`, `o_y_max` out 10 each: vertical bounding box of matches.
- `o_count` out 19: number of matching pixels in the frame.
- `o_frame_cnt` out 16: number of frames published since reset, wrapping.

## Operation
- **Match rule:** `i_visible && ((i_rgb ^ TARGET_RGB) & RGB_MASK) == 0`.
- **FSM states:**
  - WAIT_SOF: entered on reset. Accumulators are idle.
  - ACCUM: accumulating matches for the current frame.
- **FSM transitions:**
  - WAIT_SOF → ACCUM: on a visible pixel at (0,0). That pixel is accumulated in the same cycle.
  - ACCUM → ACCUM: on the visible pixel at (H_ACTIVE-1, V_ACTIVE-1), i.e. the end of frame (EOF). Results are published and the accumulators are reinitialised. The next frame then starts accumulating at its own (0,0).
- **Accumulator update on a match:**
  - `x_min = min(x_min, hpos)`, `x_max = max(x_max, hpos)`.
  - Same rule for y.
  - `count` increments by 1 and saturates at 2^19-1.
- **Accumulator initial values:** `x_min = y_min = 10'h3FF`, `x_max = y_max = 0`, `count = 0`, `hit = 0`.
- **EOF pixel:** its own match (if any) is included in the published result.
- **Published values when no match occurred:** `o_found = 0`, all box outputs = 0, `o_count = 0`.
- **Output hold:** outputs hold their values until the next publish.
- **Non-visible pixels:** ignored entirely, whatever their hpos/vpos.
- **Out-of-range visible pixels** (hpos ≥ H_ACTIVE or vpos ≥ V_ACTIVE): ignored. They do not cause EOF.
- **Frames without (0,0):** a frame that starts without (0,0) being seen is not published. The tracker stays in WAIT_SOF until it sees (0,0).

## Timing
- Accumulators register on the edge that samples the pixel.
- Publish happens on the edge that samples the EOF pixel: `o_valid` is high in the following cycle only. Latency from the EOF pixel to results is 1 cycle.
- All box, count and found outputs update on that same edge as the publish.
- `o_frame_cnt` increments on that same edge as the publish.
- **Reset:** while `i_rst_n` is low at an edge, every output goes to 0, the FSM goes to WAIT_SOF, and the accumulators are reinitialised.
- **Reset mid-frame:** the partial frame is discarded. No `o_valid` is produced until one full frame from (0,0) to EOF has been seen.
- **`o_valid` spacing:** at least one full frame apart.

## Configuration
- **`VIDEO_TRACKER_CRC_EN` defined:**
  - Adds output port `o_crc` [15:0].
  - The CRC is CRC-16/CCITT: polynomial 0x1021, initial value 0xFFFF, MSB-first.
  - It is computed over the 3-bit rgb of every visible in-range pixel of the frame from (0,0) to EOF inclusive, packed as the byte `{5'b0, rgb}`.
  - It is published with the other results on the same edge.
  - Reset value is 0.
- **Macro undefined:** there is no `o_crc` port and no CRC logic.

## Structure
- **Package `video_tracker_pkg`:**
  - Colour bit index constants (R = 0, G = 1, B = 2).
  - Reset and initial values for the min/max accumulators.
  - The CRC polynomial and CRC initial value.
  - The FSM state enum (WAIT_SOF, ACCUM).
- **Sub-module `crc16_byte_step`:** combinational next-CRC from the current CRC and a data byte. It is instantiated only under `VIDEO_TRACKER_CRC_EN`.

## Test plan
- **Single white square:** frame with white pixels exactly at x 100–107, y 50–57 and black elsewhere, default parameters. Required response: `o_valid` pulses 1 cycle after (639,479); found = 1, box = 100/107/50/57, count = 64.
- **Empty frame:** all-black frame. Required response: found = 0, box = 0, count = 0, `o_frame_cnt` increments.
- **Corner pixels:** matches at (0,0) and (639,479) only. Required response: box = 0/639/0/479, count = 2, which shows both the SOF and EOF pixels are included.
- **Mask:** `TARGET_RGB = 3'b001`, `RGB_MASK = 3'b001`; frame with red pixels (rgb 001) and yellow pixels (rgb 011). Required response: both colours are counted.
- **Reset mid-frame:** assert `i_rst_n` low at (320,240) for 2 cycles. Required response: all outputs are 0, no `o_valid` for the remainder of that frame, the next full frame publishes correctly with `o_frame_cnt = 1`.
- **CRC build (`VIDEO_TRACKER_CRC_EN` defined):** all-black frame. Required response: `o_crc` equals the reference-model CRC of 307200 zero bytes, and two identical frames give equal `o_crc` values.

Source files
------------

// File: rtl/video_tracker_pkg.sv
// video_tracker_pkg
//   Shared constants and types for video_object_tracker.
//   - colour bit indices within the 3-bit rgb word
//   - initial values for the bounding-box and count accumulators
//   - CRC-16/CCITT polynomial and seed (used only when VIDEO_TRACKER_CRC_EN is defined)
//   - tracker FSM state enum
package video_tracker_pkg;

  localparam int COL_R = 0;
  localparam int COL_G = 1;
  localparam int COL_B = 2;

  localparam logic [9:0] MIN_INIT = 10'h3FF;
  localparam logic [9:0] MAX_INIT = 10'h000;

  localparam int               CNT_W   = 19;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } trk_state_e;

endpackage

// File: rtl/crc16_byte_step.sv
// crc16_byte_step
//   Combinational CRC-16/CCITT update of one byte, MSB first.
//   Ports:
//     crc      in  16  current CRC
//     data     in  8   byte to fold in
//     crc_next out 16  CRC after the byte
module crc16_byte_step
  import video_tracker_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  logic [15:0] c;

  always_comb begin
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_next = c;
  end

endmodule

// File: rtl/video_object_tracker.sv
// video_object_tracker
//   Passive monitor of a pixel stream. Accumulates the bounding box and count
//   of visible pixels matching TARGET_RGB (under RGB_MASK) between the
//   (0,0) pixel and the (H_ACTIVE-1, V_ACTIVE-1) pixel, and publishes the
//   result one cycle after that last pixel is sampled.
//   Optional build macro: VIDEO_TRACKER_CRC_EN adds o_crc, a CRC-16/CCITT of
//   every in-range visible pixel's {5'b0, rgb} over the frame.
//   Ports:
//     i_clk, i_rst_n           pixel clock, synchronous active-low reset
//     i_hpos, i_vpos           current pixel position
//     i_visible, i_rgb         active-area flag and pixel colour
//     o_valid                  one-cycle publish pulse
//     o_found                  last frame had at least one match
//     o_x_min..o_y_max         bounding box (0 when nothing matched)
//     o_count                  matching pixel count, saturating
//     o_frame_cnt              frames published since reset, wrapping
//     o_crc                    frame CRC (VIDEO_TRACKER_CRC_EN only)
module video_object_tracker
  import video_tracker_pkg::*;
#(
  parameter int         H_ACTIVE   = 640,
  parameter int         V_ACTIVE   = 480,
  parameter logic [2:0] TARGET_RGB = 3'b111,
  parameter logic [2:0] RGB_MASK   = 3'b111
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [9:0]       i_hpos,
  input  logic [9:0]       i_vpos,
  input  logic             i_visible,
  input  logic [2:0]       i_rgb,
  output logic             o_valid,
  output logic             o_found,
  output logic [9:0]       o_x_min,
  output logic [9:0]       o_x_max,
  output logic [9:0]       o_y_min,
  output logic [9:0]       o_y_max,
  output logic [CNT_W-1:0] o_count,
`ifdef VIDEO_TRACKER_CRC_EN
  output logic [15:0]      o_frame_cnt,
  output logic [15:0]      o_crc
`else
  output logic [15:0]      o_frame_cnt
`endif
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

  trk_state_e       state;
  logic [9:0]       x_min, x_max, y_min, y_max;
  logic [CNT_W-1:0] count;
  logic             hit;

  logic             in_range, match, sof, eof, active, take;
  logic [9:0]       x_min_n, x_max_n, y_min_n, y_max_n;
  logic [CNT_W-1:0] count_n;
  logic             hit_n;

  // "_n" values already include the current pixel, so the EOF pixel's own
  // match lands in the published result.
  always_comb begin
    in_range = i_visible && (i_hpos <= H_LAST) && (i_vpos <= V_LAST);
    match    = in_range && (((i_rgb ^ TARGET_RGB) & RGB_MASK) == 3'b000);
    sof      = in_range && (i_hpos == 10'd0) && (i_vpos == 10'd0);
    eof      = in_range && (i_hpos == H_LAST) && (i_vpos == V_LAST);
    // SOF pixel is accumulated in the same cycle the FSM leaves WAIT_SOF.
    active   = (state == ACCUM) || sof;
    take     = active && match;
    x_min_n  = (take && i_hpos < x_min) ? i_hpos : x_min;
    x_max_n  = (take && i_hpos > x_max) ? i_hpos : x_max;
    y_min_n  = (take && i_vpos < y_min) ? i_vpos : y_min;
    y_max_n  = (take && i_vpos > y_max) ? i_vpos : y_max;
    count_n  = (take && count != CNT_MAX) ? count + CNT_W'(1) : count;
    hit_n    = hit | take;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= WAIT_SOF;
      x_min       <= MIN_INIT;
      x_max       <= MAX_INIT;
      y_min       <= MIN_INIT;
      y_max       <= MAX_INIT;
      count       <= '0;
      hit         <= 1'b0;
      o_valid     <= 1'b0;
      o_found     <= 1'b0;
      o_x_min     <= '0;
      o_x_max     <= '0;
      o_y_min     <= '0;
      o_y_max     <= '0;
      o_count     <= '0;
      o_frame_cnt <= '0;
    end else begin
      o_valid <= 1'b0;
      if (active) begin
        state <= ACCUM;
        if (eof) begin
          o_valid     <= 1'b1;
          o_found     <= hit_n;
          o_x_min     <= hit_n ? x_min_n : 10'd0;
          o_x_max     <= hit_n ? x_max_n : 10'd0;
          o_y_min     <= hit_n ? y_min_n : 10'd0;
          o_y_max     <= hit_n ? y_max_n : 10'd0;
          o_count     <= count_n;
          o_frame_cnt <= o_frame_cnt + 16'd1;
          x_min       <= MIN_INIT;
          x_max       <= MAX_INIT;
          y_min       <= MIN_INIT;
          y_max       <= MAX_INIT;
          count       <= '0;
          hit         <= 1'b0;
        end else begin
          x_min <= x_min_n;
          x_max <= x_max_n;
          y_min <= y_min_n;
          y_max <= y_max_n;
          count <= count_n;
          hit   <= hit_n;
        end
      end
    end
  end

`ifdef VIDEO_TRACKER_CRC_EN
  logic [15:0] crc_acc, crc_step, crc_n;

  crc16_byte_step u_crc (
    .crc      (crc_acc),
    .data     ({5'b00000, i_rgb}),
    .crc_next (crc_step)
  );

  assign crc_n = (active && in_range) ? crc_step : crc_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      crc_acc <= CRC_INIT;
      o_crc   <= '0;
    end else if (active && eof) begin
      o_crc   <= crc_n;
      crc_acc <= CRC_INIT;
    end else if (active) begin
      crc_acc <= crc_n;
    end
  end
`endif

endmodule
